perf_counter_unit: RTL and testbench
====================================

// Module: perf_counter_unit
// PURPOSE
//  Hardware performance-counter block for the pipelined processor. It counts the
//  commit and cache events that the simulation bench tallies: cycles, retired
//  instructions, D/I-cache requests and D/I-cache hits.
//  The processor reads the counts back over a 16-bit register read port with
//  one cycle of latency. It sits beside the MEM/WB stage and is clocked with the core.
// PARAMETERS
//  CNT_W   32  width of every counter; legal range 17..32
//  NUM_CNT 6   number of counters; fixed by the index map in perf_pkg
// PORTS
//  clk        in   1   core clock
//  rst        in   1   synchronous, active-high reset
//  ev_retire  in   1   one instruction committed this cycle (RegWrite|MemWrite|Halt at WB)
//  ev_ireq    in   1   valid I-cache request
//  ev_ihit    in   1   I-cache hit
//  ev_dreq    in   1   valid D-cache read or write request
//  ev_dhit    in   1   D-cache hit
//  halt       in   1   processor halted (level)
//  clr        in   1   zero all counters, shadow and error flag
//  rd_en      in   1   read request
//  rd_addr    in   4   [3:1] counter index, [0] half select (0 = low 16 bits, 1 = high bits)
//  rd_data    out  16  read data
//  rd_valid   out  1   rd_data valid
//  frozen     out  1   counters stopped because of halt
//  err        out  1   sticky flag: a hit was seen without its request
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - all counters, the shadow register, rd_data, rd_valid, frozen and err go to 0
//    - reset wins over every other input in the same cycle
//  - Counter index map: 0 CYCLE, 1 INST, 2 IREQ, 3 IHIT, 4 DREQ, 5 DHIT.
//  - Counting:
//    - CYCLE increments every cycle while not frozen
//    - each other counter increments by 1 in a cycle where its event is 1 and the unit is not frozen
//    - every counter saturates at 2^CNT_W-1; it does not wrap
//  - Freeze:
//    - frozen sets on the cycle after halt is first seen at 1, and stays set until clr or rst
//    - the events sampled in the halt cycle itself are still counted
//  - clr:
//    - zeroes counters, shadow, err and frozen in the next cycle
//    - clr together with events: clr wins and those events are lost
//  - err: sets when ev_ihit & ~ev_ireq or ev_dhit & ~ev_dreq is sampled; sticky; cleared by clr/rst.
//  - Read timing: rd_en sampled at edge N gives rd_valid=1 and rd_data at edge N+1. rd_valid is 0 otherwise.
//  - Coherent 32-bit read:
//    - a low-half read returns cnt[15:0] and, in the same cycle, latches cnt[CNT_W-1:16] into a shadow register
//    - a high-half read returns the shadow, zero-extended to 16 bits, so a low-then-high pair is consistent
//    - a high-half read with no prior low-half read returns the shadow's reset value 0
//    - the read value is the counter before that cycle's increment
//  - Reads to index 6..7 return 0 with rd_valid=1 and do not change the shadow.
//  - A read does not stall or disturb counting. Reads remain legal while frozen.
//  - clr and rd_en in the same cycle: the read returns the pre-clear value and the shadow ends up 0.
// STRUCTURE
//  - perf_pkg holds:
//    - localparams CNT_CYCLE..CNT_DHIT (indices 0..5) and NUM_CNT
//    - the address field positions and PERF_RD_W=16
//  - Sub-module perf_sat_counter (CNT_W, inc, clr, en -> q): a single saturating counter,
//    instantiated NUM_CNT times.
//  - The top level holds the freeze/err flags, read mux, shadow register and output registers.
// TESTING
//  1. rst held 2 cycles, then 10 idle cycles -> CYCLE low reads 10 (clock rst low at the edge of cycle 0); all other counters 0; err=0.
//  2. ev_dreq=1 for 5 cycles with ev_dhit=1 in 3 of them, then read idx 4 low and idx 5 low
//     -> reads return 5 and 3; rd_valid pulses exactly 1 cycle after each rd_en.
//  3. Force INST to 0x0000FFFF, then pulse ev_retire, then read low then high
//     -> 0x0000 then 0x0001. A second low/high pair taken while incrementing stays coherent.
//  4. CNT_W=17, preload 0x1FFFF, ev_retire held high -> value stays 0x1FFFF; no wrap.
//  5. halt=1 at cycle 20 with ev_retire=1 -> that retire is counted; frozen=1 from cycle 21;
//     CYCLE stays constant; clr -> all 0 and frozen=0.
//  6. ev_ihit=1 with ev_ireq=0 -> err=1 next cycle and stays 1; a rst mid-read -> rd_valid=0 and err=0.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: counter index map and register read-port layout for the performance counters
package perf_pkg;

    localparam int CNT_CYCLE = 0;
    localparam int CNT_INST  = 1;
    localparam int CNT_IREQ  = 2;
    localparam int CNT_IHIT  = 3;
    localparam int CNT_DREQ  = 4;
    localparam int CNT_DHIT  = 5;
    localparam int NUM_CNT   = 6;

    localparam int PERF_RD_W   = 16;
    localparam int RD_ADDR_W   = 4;
    localparam int RD_HALF_BIT = 0;
    localparam int RD_IDX_LSB  = 1;
    localparam int RD_IDX_MSB  = 3;
    localparam int RD_IDX_W    = RD_IDX_MSB - RD_IDX_LSB + 1;

    typedef logic [RD_IDX_W-1:0] rdIdx_t;

    function automatic rdIdx_t rdIdxOf(input logic [RD_ADDR_W-1:0] addr);
        return addr[RD_IDX_MSB:RD_IDX_LSB];
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: single event counter that saturates at all-ones instead of wrapping
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    // Add one on an enabled event unless already at the ceiling; clear has priority
    always_ff @(posedge clk)
        q <= (rst || clr) ? '0 : q + CNT_W'(en && inc && !(&q));

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: core performance counters with freeze-on-halt and a coherent 16-bit read port
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ev_retire,
    input  logic                 ev_ireq,
    input  logic                 ev_ihit,
    input  logic                 ev_dreq,
    input  logic                 ev_dhit,
    input  logic                 halt,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic [RD_ADDR_W-1:0] rd_addr,
    output logic [PERF_RD_W-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frozen,
    output logic                 err
);

    localparam int SH_W = CNT_W - PERF_RD_W;

    logic [NUM_CNT-1:0] evVec;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [CNT_W-1:0]   selCnt;
    logic               selHit;
    logic [SH_W-1:0]    shadow;
    rdIdx_t             rdIdx;
    logic               rdHigh;
    logic               lowRead;

    assign evVec[CNT_CYCLE] = 1'b1;
    assign evVec[CNT_INST]  = ev_retire;
    assign evVec[CNT_IREQ]  = ev_ireq;
    assign evVec[CNT_IHIT]  = ev_ihit;
    assign evVec[CNT_DREQ]  = ev_dreq;
    assign evVec[CNT_DHIT]  = ev_dhit;

    assign rdIdx   = rdIdxOf(rd_addr);
    assign rdHigh  = rd_addr[RD_HALF_BIT];
    assign lowRead = rd_en && selHit && !rdHigh;

    for (genvar i = 0; i < NUM_CNT; i++) begin : gCnt
        perf_sat_counter #(.CNT_W(CNT_W)) uCnt (
            .clk (clk),
            .rst (rst),
            .inc (evVec[i]),
            .clr (clr),
            .en  (!frozen),
            .q   (cnt[i])
        );
    end

    // Select the addressed counter; unmapped indices leave selHit low
    always_comb begin
        selCnt = '0;
        selHit = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rdIdx == RD_IDX_W'(k)) begin
                selCnt = cnt[k];
                selHit = 1'b1;
            end
        end
    end

    // Freeze one cycle after halt so the halting instruction is still counted; err is sticky
    always_ff @(posedge clk) begin
        frozen <= (rst || clr) ? 1'b0 : frozen | halt;
        err    <= (rst || clr) ? 1'b0 : err | (ev_ihit & ~ev_ireq) | (ev_dhit & ~ev_dreq);
    end

    // Low-half reads capture the upper bits so the following high-half read matches them
    always_ff @(posedge clk)
        shadow <= (rst || clr) ? '0 : lowRead ? selCnt[CNT_W-1:PERF_RD_W] : shadow;

    // Registered read port: data returns one cycle after the request
    always_ff @(posedge clk) begin
        rd_valid <= !rst && rd_en;
        rd_data  <= (rst || !rd_en || !selHit) ? '0 :
                    rdHigh ? PERF_RD_W'(shadow) : selCnt[PERF_RD_W-1:0];
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: directed table-driven and sequence checks of the performance counter unit
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        rst, ev_retire, ev_ireq, ev_ihit, ev_dreq, ev_dhit, halt, clr, rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data, rdData17;
    logic        rd_valid, frozen, err, rdValid17, frozen17, err17;
    int          nVec = 0;
    int          nBad = 0;

    typedef struct {
        logic        retire, ireq, ihit, dreq, dhit, clr, rdEn;
        logic [3:0]  addr;
        logic        expValid;
        logic [15:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

    perf_counter_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ev_retire(ev_retire), .ev_ireq(ev_ireq), .ev_ihit(ev_ihit),
        .ev_dreq(ev_dreq), .ev_dhit(ev_dhit), .halt(halt), .clr(clr), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .frozen(frozen), .err(err)
    );

    perf_counter_unit #(.CNT_W(17)) dut17 (
        .clk(clk), .rst(rst), .ev_retire(ev_retire), .ev_ireq(ev_ireq), .ev_ihit(ev_ihit),
        .ev_dreq(ev_dreq), .ev_dhit(ev_dhit), .halt(halt), .clr(clr), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rdData17), .rd_valid(rdValid17), .frozen(frozen17), .err(err17)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string name);
        rd_en = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({name, " valid"}, {31'd0, rd_valid}, 32'd1);
        chk(name, {16'd0, rd_data}, {16'd0, exp});
    endtask

    initial begin
        {ev_retire, ev_ireq, ev_ihit, ev_dreq, ev_dhit, halt, clr, rd_en} = '0;
        rd_addr = '0;
        rst = 1'b1;
        step();
        chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst frozen", {31'd0, frozen}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        rd(4'h0, 16'd10, "cycle after 10 idle");
        step();
        chk("rd_valid single pulse", {31'd0, rd_valid}, 32'd0);
        rd(4'h1, 16'd0, "cycle high");
        rd(4'h2, 16'd0, "inst idle");
        rd(4'h4, 16'd0, "ireq idle");
        rd(4'h6, 16'd0, "ihit idle");
        rd(4'h8, 16'd0, "dreq idle");
        rd(4'hA, 16'd0, "dhit idle");
        rd(4'hC, 16'd0, "index 6");
        chk("err idle", {31'd0, err}, 32'd0);

        vecs[0]  = '{0, 1, 1, 1, 1, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[1]  = '{0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[2]  = '{1, 0, 0, 1, 1, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 4'h8, 1, 16'd5, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 4'hA, 1, 16'd3, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 16'd0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 4'h9, 1, 16'd0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 4'h6, 1, 16'd1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 4'h4, 1, 16'd2, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 4'h2, 1, 16'd2, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 4'hE, 1, 16'd0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 1, 4'hF, 1, 16'd0, 0};
        vecs[14] = '{0, 0, 0, 1, 0, 1, 1, 4'h8, 1, 16'd5, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 4'h8, 1, 16'd0, 0};
        vecs[16] = '{1, 0, 0, 0, 0, 0, 1, 4'h2, 1, 16'd0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 1, 4'h2, 1, 16'd1, 0};
        for (int i = 0; i < 18; i++) begin
            {ev_retire, ev_ireq, ev_ihit, ev_dreq, ev_dhit, clr, rd_en} =
                {vecs[i].retire, vecs[i].ireq, vecs[i].ihit, vecs[i].dreq, vecs[i].dhit, vecs[i].clr, vecs[i].rdEn};
            rd_addr = vecs[i].addr;
            step();
            chk($sformatf("vec%0d rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].expValid});
            if (vecs[i].expValid)
                chk($sformatf("vec%0d rd_data", i), {16'd0, rd_data}, {16'd0, vecs[i].expData});
            chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
            chk($sformatf("vec%0d frozen", i), {31'd0, frozen}, 32'd0);
        end
        {ev_retire, ev_ireq, ev_ihit, ev_dreq, ev_dhit, clr, rd_en} = '0;

        force dut.gCnt[1].uCnt.q = 32'h0000FFFF;
        step();
        release dut.gCnt[1].uCnt.q;
        ev_retire = 1'b1;
        step();
        ev_retire = 1'b0;
        rd(4'h2, 16'h0000, "inst low after carry");
        rd(4'h3, 16'h0001, "inst high after carry");
        force dut.gCnt[1].uCnt.q = 32'h0001FFFF;
        step();
        release dut.gCnt[1].uCnt.q;
        ev_retire = 1'b1;
        rd(4'h2, 16'hFFFF, "inst low while counting");
        rd(4'h3, 16'h0001, "inst high coherent");
        ev_retire = 1'b0;
        clr = 1'b1;
        rd(4'h2, 16'h0001, "read with clr pre-clear");
        clr = 1'b0;
        rd(4'h3, 16'h0000, "shadow cleared by clr");
        rd(4'h2, 16'h0000, "inst cleared");

        force dut17.gCnt[1].uCnt.q = 17'h1FFFF;
        step();
        release dut17.gCnt[1].uCnt.q;
        ev_retire = 1'b1;
        repeat (3) step();
        rd_en = 1'b1;
        rd_addr = 4'h2;
        step();
        chk("w17 low valid", {31'd0, rdValid17}, 32'd1);
        chk("w17 low saturated", {16'd0, rdData17}, 32'h0000FFFF);
        rd_addr = 4'h3;
        step();
        rd_en = 1'b0;
        ev_retire = 1'b0;
        chk("w17 high saturated", {16'd0, rdData17}, 32'h00000001);
        chk("w17 frozen", {31'd0, frozen17}, 32'd0);
        chk("w17 err", {31'd0, err17}, 32'd0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (19) step();
        chk("frozen before halt", {31'd0, frozen}, 32'd0);
        halt = 1'b1;
        ev_retire = 1'b1;
        step();
        chk("frozen after halt", {31'd0, frozen}, 32'd1);
        rd(4'h0, 16'd20, "cycle at freeze");
        repeat (3) step();
        rd(4'h0, 16'd20, "cycle held while frozen");
        rd(4'h2, 16'd1, "halt-cycle retire counted");
        chk("frozen sticky", {31'd0, frozen}, 32'd1);
        halt = 1'b0;
        ev_retire = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("frozen cleared by clr", {31'd0, frozen}, 32'd0);
        rd(4'h0, 16'd0, "cycle after clr");
        rd(4'h2, 16'd0, "inst after clr");

        ev_ihit = 1'b1;
        step();
        ev_ihit = 1'b0;
        chk("err on ihit without ireq", {31'd0, err}, 32'd1);
        repeat (3) step();
        chk("err sticky", {31'd0, err}, 32'd1);
        rd_en = 1'b1;
        rd_addr = 4'h0;
        step();
        chk("read in flight", {31'd0, rd_valid}, 32'd1);
        rst = 1'b1;
        ev_retire = 1'b1;
        step();
        chk("rst mid-read rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst mid-read rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst clears err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        rd_en = 1'b0;
        ev_retire = 1'b0;
        rd(4'h2, 16'd0, "rst wins over retire");
        ev_dhit = 1'b1;
        step();
        ev_dhit = 1'b0;
        chk("err on dhit without dreq", {31'd0, err}, 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("err cleared by clr", {31'd0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
